i2c_bus_arbiter: RTL and testbench
==================================

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 4096: maximum grant length in sys_clk cycles before forced release.
REQ-002 Parameter GAP_CYCLES, 2: bus-idle cycles between grants, with reset_I2C held high.
REQ-003 Port sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port req0  in  1  requester 0 (memory writer) bus request.
REQ-006 Port req1  in  1  requester 1 (measurement reader) bus request.
REQ-007 Port done0 / done1  in  1 each  requester transaction complete (stop issued).
REQ-008 Port cmd0 / cmd1  in  20 each  {slave_address[19:13], byte[12:5], mode[4], en[3], start[2], stop[1], repeat_start[0]}.
REQ-009 Port ack  in  1  acknowledge from the I2C master.
REQ-010 Port gnt0 / gnt1  out  1 each  bus granted to requester n.
REQ-011 Port ack0 / ack1  out  1 each  master ack routed to the granted requester only.
REQ-012 Port slave_address  out  7  to master.
REQ-013 Port byte_to_be_writen  out  8  to master.
REQ-014 Port I2C_mode, I2C_en, I2C_start, I2C_stop, I2C_repeat_start  out  1 each  to master.
REQ-015 Port reset_I2C  out  1  master reset, high during GAP.
REQ-016 Port timeout_err  out  1  one-cycle pulse on forced release.

Function
REQ-017 FSM states: IDLE, GRANT0, GRANT1, GAP; state and last_gnt are registered.
REQ-018 IDLE: req0 only -> GRANT0; req1 only -> GRANT1; both -> the requester not equal to last_gnt; neither -> stay in IDLE.
REQ-019 gntn SHALL assert exactly one cycle after reqn is sampled in IDLE; gnt0 and gnt1 SHALL never both be high.
REQ-020 In GRANTn, master outputs SHALL equal the cmdn fields combinationally (zero latency), and ackn SHALL equal ack.
REQ-021 In IDLE and GAP, all master command outputs SHALL be 0 (I2C_en=0), and ack0=ack1=0.
REQ-022 GRANTn -> GAP when donen=1, or reqn=0 (abort, no error), or the grant timer reaches TIMEOUT_CYCLES-1.
REQ-023 Grant timer: clears on entry to GRANTn, increments each GRANTn cycle, and is sized as clog2(TIMEOUT_CYCLES).
REQ-024 On timeout without done, timeout_err SHALL pulse high for the GRANTn->GAP transition cycle.
REQ-025 If done and timeout occur in the same cycle, done wins: no timeout_err.
REQ-026 On leaving GRANTn, last_gnt SHALL be set to n.
REQ-027 GAP: reset_I2C=1 for exactly GAP_CYCLES cycles, then -> IDLE; requests arriving during GAP are held off until IDLE.
REQ-028 A request that stays asserted through GAP SHALL be re-arbitrated normally in IDLE.

Reset
REQ-029 reset=1 at a clock edge forces state=IDLE, last_gnt=1 (requester 0 wins the first tie), timer=0, all outputs 0, including mid-grant.
REQ-030 Reset SHALL take precedence over every transition condition.

Structure
REQ-031 Shared package i2c_arb_pkg SHALL hold the state enum, cmd field offsets/width (20), and parameter defaults.
REQ-032 The grant timer SHALL be one sub-module, i2c_arb_timer (clear, enable, terminal-count output).

Verification
REQ-033 req0=1 alone -> gnt0 high next cycle; cmd0=0xABCDE appears on master outputs the same cycle; done0 -> GAP with reset_I2C high for 2 cycles -> IDLE.
REQ-034 req0=req1=1 from reset -> GRANT0 first; after done0 and the gap, GRANT1; then both again -> GRANT0 (alternation).
REQ-035 req1 held, no done1, TIMEOUT_CYCLES=16 -> gnt1 drops after 16 grant cycles with a single timeout_err pulse.
REQ-036 done0 asserted on the timeout cycle -> release occurs, timeout_err stays 0.
REQ-037 reset asserted mid-GRANT1 -> next cycle all outputs 0 and state IDLE; with both requests high, the next grant goes to requester 0.
REQ-038 ack toggled during GRANT0 -> ack0 follows it, ack1 stays 0; in GAP both stay 0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the two-requester I2C bus arbiter: FSM states,
// command word field layout and default parameter values.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_t;

    // Command word: {slave_address, byte, mode, en, start, stop, repeat_start}
    localparam int CMD_W      = 20;
    localparam int ADDR_MSB   = 19;
    localparam int ADDR_LSB   = 13;
    localparam int BYTE_MSB   = 12;
    localparam int BYTE_LSB   = 5;
    localparam int MODE_BIT   = 4;
    localparam int EN_BIT     = 3;
    localparam int START_BIT  = 2;
    localparam int STOP_BIT   = 1;
    localparam int RSTART_BIT = 0;

    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int DEF_GAP_CYCLES     = 2;

endpackage

// File: rtl/i2c_arb_timer.sv
// Grant-length timer: counts enabled cycles from zero and flags the cycle
// in which the count reaches TERMINAL-1.
module i2c_arb_timer #(
    parameter int TERMINAL = 4096,
    parameter int WIDTH    = (TERMINAL > 1) ? $clog2(TERMINAL) : 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = i_enable && (r_count == TC_VAL);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Arbitrates one I2C master between two requesters, alternating on ties,
// with a forced-release timeout and a master-reset gap between grants.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             done0,
    input  logic             done1,
    input  logic [CMD_W-1:0] cmd0,
    input  logic [CMD_W-1:0] cmd1,
    input  logic             ack,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic [6:0]       slave_address,
    output logic [7:0]       byte_to_be_writen,
    output logic             I2C_mode,
    output logic             I2C_en,
    output logic             I2C_start,
    output logic             I2C_stop,
    output logic             I2C_repeat_start,
    output logic             reset_I2C,
    output logic             timeout_err,
    output arb_state_t       o_state
);

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic             r_last_gnt;
    logic             w_next_last_gnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             w_in_grant;
    logic             w_tc;
    logic [CMD_W-1:0] w_cmd;

    assign w_in_grant = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);

    // Timer is held at zero outside a grant, so it starts fresh on every grant entry.
    i2c_arb_timer #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (sys_clk),
        .i_reset  (reset),
        .i_clear  (!w_in_grant),
        .i_enable (w_in_grant),
        .o_tc     (w_tc)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_last_gnt <= w_next_last_gnt;
            if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_last_gnt = r_last_gnt;
        w_cmd           = '0;
        gnt0            = 1'b0;
        gnt1            = 1'b0;
        ack0            = 1'b0;
        ack1            = 1'b0;
        reset_I2C       = 1'b0;
        timeout_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie, the requester that did not hold the bus last wins.
                if (req0 && req1) begin
                    w_next_state = r_last_gnt ? ST_GRANT0 : ST_GRANT1;
                end else if (req0) begin
                    w_next_state = ST_GRANT0;
                end else if (req1) begin
                    w_next_state = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                gnt0  = 1'b1;
                ack0  = ack;
                w_cmd = cmd0;
                if (done0 || !req0 || w_tc) begin
                    w_next_state    = ST_GAP;
                    w_next_last_gnt = 1'b0;
                    timeout_err     = w_tc && !done0;
                end
            end
            ST_GRANT1: begin
                gnt1  = 1'b1;
                ack1  = ack;
                w_cmd = cmd1;
                if (done1 || !req1 || w_tc) begin
                    w_next_state    = ST_GAP;
                    w_next_last_gnt = 1'b1;
                    timeout_err     = w_tc && !done1;
                end
            end
            ST_GAP: begin
                reset_I2C = 1'b1;
                if (r_gap_cnt == GAP_LAST) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign slave_address     = w_cmd[ADDR_MSB:ADDR_LSB];
    assign byte_to_be_writen = w_cmd[BYTE_MSB:BYTE_LSB];
    assign I2C_mode          = w_cmd[MODE_BIT];
    assign I2C_en            = w_cmd[EN_BIT];
    assign I2C_start         = w_cmd[START_BIT];
    assign I2C_stop          = w_cmd[STOP_BIT];
    assign I2C_repeat_start  = w_cmd[RSTART_BIT];
    assign o_state           = r_state;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a short timeout (16) and gap (2).
module tb_i2c_bus_arbiter;
    import i2c_arb_pkg::*;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, done0 = 1'b0, done1 = 1'b0, ack = 1'b0;
    logic [19:0] cmd0 = '0, cmd1 = '0;
    logic        gnt0, gnt1, ack0, ack1;
    logic [6:0]  slave_address;
    logic [7:0]  byte_to_be_writen;
    logic        I2C_mode, I2C_en, I2C_start, I2C_stop, I2C_repeat_start;
    logic        reset_I2C, timeout_err;
    arb_state_t  o_state;

    logic [5:0]  w_ctrl;
    logic [19:0] w_bus;
    int          errors = 0;
    int          checks = 0;

    assign w_ctrl = {gnt0, gnt1, ack0, ack1, reset_I2C, timeout_err};
    assign w_bus  = {slave_address, byte_to_be_writen, I2C_mode, I2C_en,
                     I2C_start, I2C_stop, I2C_repeat_start};

    i2c_bus_arbiter #(
        .TIMEOUT_CYCLES (16),
        .GAP_CYCLES     (2)
    ) dut (
        .sys_clk           (sys_clk),
        .reset             (reset),
        .req0              (req0),
        .req1              (req1),
        .done0             (done0),
        .done1             (done1),
        .cmd0              (cmd0),
        .cmd1              (cmd1),
        .ack               (ack),
        .gnt0              (gnt0),
        .gnt1              (gnt1),
        .ack0              (ack0),
        .ack1              (ack1),
        .slave_address     (slave_address),
        .byte_to_be_writen (byte_to_be_writen),
        .I2C_mode          (I2C_mode),
        .I2C_en            (I2C_en),
        .I2C_start         (I2C_start),
        .I2C_stop          (I2C_stop),
        .I2C_repeat_start  (I2C_repeat_start),
        .reset_I2C         (reset_I2C),
        .timeout_err       (timeout_err),
        .o_state           (o_state)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance one edge and settle 1 ns past it.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; done0 = 1'b0; done1 = 1'b0; ack = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req0 = 1'b1; req1 = 1'b1; reset = 1'b1;
        tick();
        checks++; if (o_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", o_state, ST_IDLE); end
        checks++; if (w_ctrl !== 6'b000000) begin errors++; $display("FAIL reset_ctrl got %b exp 000000", w_ctrl); end
        checks++; if (w_bus !== 20'h0) begin errors++; $display("FAIL reset_bus got %h exp 00000", w_bus); end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_single_grant();
        do_reset();
        cmd0 = 20'hABCDE; req0 = 1'b1;
        tick();
        checks++; if (w_ctrl !== 6'b100000) begin errors++; $display("FAIL single_gnt got %b exp 100000", w_ctrl); end
        checks++; if (w_bus !== 20'hABCDE) begin errors++; $display("FAIL single_bus got %h exp abcde", w_bus); end
        cmd0 = 20'h12345; #1;
        checks++; if (w_bus !== 20'h12345) begin errors++; $display("FAIL single_bus_comb got %h exp 12345", w_bus); end
        done0 = 1'b1;
        tick();
        done0 = 1'b0; req0 = 1'b0;
        checks++; if (w_ctrl !== 6'b000010) begin errors++; $display("FAIL single_gap1 got %b exp 000010", w_ctrl); end
        checks++; if (w_bus !== 20'h0) begin errors++; $display("FAIL single_gap_bus got %h exp 00000", w_bus); end
        tick();
        checks++; if (w_ctrl !== 6'b000010) begin errors++; $display("FAIL single_gap2 got %b exp 000010", w_ctrl); end
        tick();
        checks++; if (o_state !== ST_IDLE || w_ctrl !== 6'b000000) begin errors++; $display("FAIL single_idle got st=%0d ctrl=%b exp st=0 ctrl=000000", o_state, w_ctrl); end
    endtask

    task automatic test_alternation();
        do_reset();
        cmd0 = 20'h11111; cmd1 = 20'h22222; req0 = 1'b1; req1 = 1'b1;
        tick();
        checks++; if (w_ctrl !== 6'b100000 || w_bus !== 20'h11111) begin errors++; $display("FAIL alt_first got ctrl=%b bus=%h exp 100000/11111", w_ctrl, w_bus); end
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        tick();
        tick();
        checks++; if (o_state !== ST_IDLE) begin errors++; $display("FAIL alt_idle1 got %0d exp 0", o_state); end
        tick();
        checks++; if (w_ctrl !== 6'b010000 || w_bus !== 20'h22222) begin errors++; $display("FAIL alt_second got ctrl=%b bus=%h exp 010000/22222", w_ctrl, w_bus); end
        ack = 1'b1; #1;
        checks++; if (w_ctrl !== 6'b010100) begin errors++; $display("FAIL alt_ack1 got %b exp 010100", w_ctrl); end
        ack = 1'b0; done1 = 1'b1;
        tick();
        done1 = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (w_ctrl !== 6'b100000 || w_bus !== 20'h11111) begin errors++; $display("FAIL alt_third got ctrl=%b bus=%h exp 100000/11111", w_ctrl, w_bus); end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        do_reset();
        cmd1 = 20'h5A5A5; req1 = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            checks++; if (w_ctrl !== 6'b010000) begin errors++; $display("FAIL to_hold cyc=%0d got %b exp 010000", i, w_ctrl); end
            if (timeout_err === 1'b1) pulses++;
            tick();
        end
        checks++; if (w_ctrl !== 6'b010001) begin errors++; $display("FAIL to_last got %b exp 010001", w_ctrl); end
        if (timeout_err === 1'b1) pulses++;
        tick();
        checks++; if (w_ctrl !== 6'b000010) begin errors++; $display("FAIL to_gap got %b exp 000010", w_ctrl); end
        if (timeout_err === 1'b1) pulses++;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL to_pulses got %0d exp 1", pulses); end
        tick();
        tick();
        checks++; if (o_state !== ST_IDLE) begin errors++; $display("FAIL to_rearb_idle got %0d exp 0", o_state); end
        tick();
        checks++; if (w_ctrl !== 6'b010000) begin errors++; $display("FAIL to_regrant got %b exp 010000", w_ctrl); end
        req1 = 1'b0; #1;
        checks++; if (w_ctrl !== 6'b010000) begin errors++; $display("FAIL abort_noerr got %b exp 010000", w_ctrl); end
        tick();
        checks++; if (o_state !== ST_GAP) begin errors++; $display("FAIL abort_gap got %0d exp 3", o_state); end
    endtask

    task automatic test_done_on_timeout();
        do_reset();
        req0 = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        done0 = 1'b1; #1;
        checks++; if (w_ctrl !== 6'b100000) begin errors++; $display("FAIL done_wins got %b exp 100000", w_ctrl); end
        tick();
        done0 = 1'b0; req0 = 1'b0;
        checks++; if (w_ctrl !== 6'b000010) begin errors++; $display("FAIL done_wins_gap got %b exp 000010", w_ctrl); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        cmd1 = 20'h7FFFF; req1 = 1'b1;
        tick();
        tick();
        checks++; if (w_ctrl !== 6'b010000) begin errors++; $display("FAIL mid_pre got %b exp 010000", w_ctrl); end
        req0 = 1'b1; ack = 1'b1; reset = 1'b1;
        tick();
        checks++; if (o_state !== ST_IDLE || w_ctrl !== 6'b000000 || w_bus !== 20'h0) begin errors++; $display("FAIL mid_reset got st=%0d ctrl=%b bus=%h exp 0/000000/00000", o_state, w_ctrl, w_bus); end
        reset = 1'b0; ack = 1'b0;
        tick();
        checks++; if (w_ctrl !== 6'b100000) begin errors++; $display("FAIL mid_next got %b exp 100000", w_ctrl); end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_ack();
        do_reset();
        req0 = 1'b1;
        tick();
        ack = 1'b1; #1;
        checks++; if (w_ctrl !== 6'b101000) begin errors++; $display("FAIL ack_hi got %b exp 101000", w_ctrl); end
        ack = 1'b0; #1;
        checks++; if (w_ctrl !== 6'b100000) begin errors++; $display("FAIL ack_lo got %b exp 100000", w_ctrl); end
        ack = 1'b1; done0 = 1'b1;
        tick();
        done0 = 1'b0;
        checks++; if (w_ctrl !== 6'b000010) begin errors++; $display("FAIL ack_gap got %b exp 000010", w_ctrl); end
        ack = 1'b0; req0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_alternation();
        test_timeout();
        test_done_on_timeout();
        test_reset_mid_grant();
        test_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
